// File: rtl/back_to_white.sv
// Card-state register for the 16-card pairs game: one registered flag per card.
// Optional build macro BACKTOWHITE_LOCK_EN makes matched cards stay coloured until rst.
module back_to_white (
  input  logic       clk,
  input  logic       rst,
  input  logic       par,
  input  logic [7:0] selected1,
  input  logic [7:0] selected2,
  output logic       par1,
  output logic       par2,
  output logic       par3,
  output logic       par4,
  output logic       par5,
  output logic       par6,
  output logic       par7,
  output logic       par8,
  output logic       par9,
  output logic       par10,
  output logic       par11,
  output logic       par12,
  output logic       par13,
  output logic       par14,
  output logic       par15,
  output logic       par16
);

  logic signed [7:0] sel1_s;
  logic signed [7:0] sel2_s;
  logic [15:0]       mask;
  logic [15:0]       flags_next;
  logic [15:0]       flags_p0;

  // One-hot card mask for a 1-based signed index; out-of-range indices select nothing.
  function automatic logic [15:0] card_mask(input logic signed [7:0] idx);
    logic [3:0] sh;
    card_mask = '0;
    if ((idx >= 8'sd1) && (idx <= 8'sd16)) begin
      sh = 4'(idx - 8'sd1);
      card_mask = 16'd1 << sh;
    end
  endfunction

  assign sel1_s = selected1;
  assign sel2_s = selected2;

  always_comb begin
    mask       = '0;
    flags_next = flags_p0;
    // A card cannot pair with itself, so an identical pair of indices is a no-op.
    if (sel1_s != sel2_s) begin
      mask = card_mask(sel1_s) | card_mask(sel2_s);
    end
    if (par) begin
      flags_next = flags_p0 | mask;
    end else begin
`ifdef BACKTOWHITE_LOCK_EN
      flags_next = flags_p0;
`else
      flags_next = flags_p0 & ~mask;
`endif
    end
  end

  // Stage p0: flag register, the only state; outputs come straight from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_p0 <= '0;
    end else begin
      flags_p0 <= flags_next;
    end
  end

  assign par1  = flags_p0[0];
  assign par2  = flags_p0[1];
  assign par3  = flags_p0[2];
  assign par4  = flags_p0[3];
  assign par5  = flags_p0[4];
  assign par6  = flags_p0[5];
  assign par7  = flags_p0[6];
  assign par8  = flags_p0[7];
  assign par9  = flags_p0[8];
  assign par10 = flags_p0[9];
  assign par11 = flags_p0[10];
  assign par12 = flags_p0[11];
  assign par13 = flags_p0[12];
  assign par14 = flags_p0[13];
  assign par15 = flags_p0[14];
  assign par16 = flags_p0[15];

endmodule

// File: tb/tb_back_to_white.sv
// Self-checking bench for back_to_white: directed scenarios plus randomized
// selections checked against a per-card reference model.
module tb_back_to_white;

  logic       clk;
  logic       rst;
  logic       par;
  logic [7:0] selected1;
  logic [7:0] selected2;
  logic       par1, par2, par3, par4, par5, par6, par7, par8;
  logic       par9, par10, par11, par12, par13, par14, par15, par16;

  int checks = 0;
  int errors = 0;
  bit model_card [1:16];

`ifdef BACKTOWHITE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  back_to_white dut (
    .clk(clk), .rst(rst), .par(par),
    .selected1(selected1), .selected2(selected2),
    .par1(par1), .par2(par2), .par3(par3), .par4(par4),
    .par5(par5), .par6(par6), .par7(par7), .par8(par8),
    .par9(par9), .par10(par10), .par11(par11), .par12(par12),
    .par13(par13), .par14(par14), .par15(par15), .par16(par16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dut_flags();
    return {par16, par15, par14, par13, par12, par11, par10, par9,
            par8, par7, par6, par5, par4, par3, par2, par1};
  endfunction

  function automatic logic [15:0] model_flags();
    logic [15:0] v;
    for (int n = 1; n <= 16; n++) v[n-1] = model_card[n];
    return v;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: apply the game rules card by card to the selected indices.
  task automatic model_update(input bit r, input bit p, input int s1, input int s2);
    int sel [2];
    if (r) begin
      for (int n = 1; n <= 16; n++) model_card[n] = 1'b0;
      return;
    end
    if (s1 == s2) return;
    sel[0] = s1;
    sel[1] = s2;
    foreach (sel[i]) begin
      if (sel[i] >= 1 && sel[i] <= 16) begin
        if (p) model_card[sel[i]] = 1'b1;
        else if (!(LOCK && model_card[sel[i]])) model_card[sel[i]] = 1'b0;
      end
    end
  endtask

  // Drive inputs just after an edge, confirm outputs hold until the next edge,
  // then check the new state one edge later.
  task automatic step(input string tag, input bit r, input bit p, input int s1, input int s2);
    rst       = r;
    par       = p;
    selected1 = s1[7:0];
    selected2 = s2[7:0];
    #1;
    check({tag, "_hold"}, dut_flags(), model_flags());
    @(posedge clk);
    model_update(r, p, s1, s2);
    #1;
    check(tag, dut_flags(), model_flags());
  endtask

  initial begin
    int s1, s2;
    bit r, p;
    rst = 1'b1; par = 1'b0; selected1 = 8'd0; selected2 = 8'd0;
    for (int n = 1; n <= 16; n++) model_card[n] = 1'b0;
    @(posedge clk); #1;

    // Reset held with an active match request on the inputs
    step("rst_a", 1'b1, 1'b1, 3, 6);
    check("rst_a_zero", dut_flags(), 16'h0000);
    step("rst_b", 1'b1, 1'b1, 3, 6);
    check("rst_b_zero", dut_flags(), 16'h0000);

    step("match", 1'b0, 1'b1, 3, 6);
    check("match_const", dut_flags(), 16'h0024);
    step("unmatch", 1'b0, 1'b0, 3, 6);
    check("unmatch_const", dut_flags(), LOCK ? 16'h0024 : 16'h0000);

    step("rst_c", 1'b1, 1'b0, 0, 0);
    step("miss", 1'b0, 1'b0, 3, 6);
    check("miss_const", dut_flags(), 16'h0000);
    step("edges", 1'b0, 1'b1, 1, 16);
    check("edges_const", dut_flags(), 16'h8001);

    step("rst_d", 1'b1, 1'b0, 0, 0);
    step("out_rng", 1'b0, 1'b1, 0, 17);
    check("out_rng_const", dut_flags(), 16'h0000);
    step("neg", 1'b0, 1'b1, -3, 5);
    check("neg_const", dut_flags(), 16'h0010);
    step("same", 1'b0, 1'b1, 7, 7);
    check("same_const", dut_flags(), 16'h0010);
    step("idem", 1'b0, 1'b1, -3, 5);
    check("idem_const", dut_flags(), 16'h0010);

    // Reset priority over a simultaneous match
    step("rst_e", 1'b1, 1'b0, 0, 0);
    step("set29", 1'b0, 1'b1, 2, 9);
    check("set29_const", dut_flags(), 16'h0102);
    step("rst_prio", 1'b1, 1'b1, 4, 5);
    check("rst_prio_const", dut_flags(), 16'h0000);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        s1 = int'($signed(8'($urandom)));
        s2 = int'($signed(8'($urandom)));
      end else begin
        s1 = int'($urandom_range(0, 24)) - 4;
        s2 = int'($urandom_range(0, 24)) - 4;
      end
      if ($urandom_range(0, 15) == 0) s2 = s1;
      r = ($urandom_range(0, 49) == 0);
      p = 1'($urandom);
      step("rand", r, p, s1, s2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
